// File: rtl/mfp_ahb_arbiter2.sv
// Two-master AHB-Lite arbiter: core (m0) and serial loader (m1) share one
// fabric port. Address phase follows the registered grant, write data follows
// the registered data-phase owner. A hold counter bounds how long one master
// can keep the bus while the other waits.

module mfp_ahb_arbiter2 #(
  parameter int unsigned HOLD_MAX = 16,
  parameter bit          M1_HIGH  = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        m0_req,
  input  logic [31:0] m0_HADDR,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  input  logic [31:0] m0_HWDATA,
  output logic        m0_HREADY,

  input  logic        m1_req,
  input  logic [31:0] m1_HADDR,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  input  logic [31:0] m1_HWDATA,
  output logic        m1_HREADY,

  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,

  output logic [1:0]  grant
);

  localparam int unsigned CntW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_MAX);
  localparam logic [1:0] TransIdle = 2'b00;

  typedef enum logic [0:0] {StOwn0, StOwn1} state_e;

  state_e          state_q;
  logic [1:0]      grant_q;
  logic            data_owner_q;  // 0 = m0, 1 = m1
  logic [CntW-1:0] hold_cnt_q;
  logic [CntW-1:0] hold_cnt_d;
  logic            m0_req_q;
  logic            m1_req_q;

  logic            own_m1;
  logic            owner_req;
  logic            other_req;
  logic [1:0]      owner_htrans;
  logic            hold_full;
  logic            preempt;
  logic            simul_rise;
  logic            prio_is_owner;
  logic            releasing;
  logic            handover;

  // Current owner's view of the request/transfer inputs.
  always_comb begin
    own_m1       = (state_q == StOwn1);
    owner_req    = own_m1 ? m1_req    : m0_req;
    other_req    = own_m1 ? m0_req    : m1_req;
    owner_htrans = own_m1 ? m1_HTRANS : m0_HTRANS;
  end

  // Handover decision for the next edge.
  always_comb begin
    hold_full     = (hold_cnt_q == HoldMax);
    // Owner has used its quota and the other master is waiting: its pending
    // address phase must not reach the fabric.
    preempt       = other_req & hold_full;
    // Both requests rising together: the priority master wins an idle bus.
    simul_rise    = ~m0_req_q & ~m1_req_q & m0_req & m1_req;
    prio_is_owner = simul_rise & (M1_HIGH == own_m1);
    releasing     = ~owner_req | (owner_htrans == TransIdle) | hold_full;
    handover      = HREADY & other_req & releasing & ~prio_is_owner;
  end

  // Hold counter: counts accepted owner beats while the other master waits.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (handover || !other_req) begin
      hold_cnt_d = '0;
    end else if (HREADY && owner_htrans[1] && !hold_full) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end
  end

  // Ownership FSM with registered one-hot grant.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= StOwn0;
      grant_q <= 2'b01;
    end else if (handover) begin
      state_q <= own_m1 ? StOwn0 : StOwn1;
      grant_q <= own_m1 ? 2'b01 : 2'b10;
    end
  end

  // Data-phase owner follows the address phase that was actually accepted.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_owner_q <= 1'b0;
    end else if (HREADY) begin
      // A preempted owner's address phase was suppressed, so no data phase
      // of its own follows.
      data_owner_q <= preempt ? ~own_m1 : own_m1;
    end
  end

  // Hold counter and request history for simultaneous-request detection.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_cnt_q <= '0;
      m0_req_q   <= 1'b0;
      m1_req_q   <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      m0_req_q   <= m0_req;
      m1_req_q   <= m1_req;
    end
  end

  // Fabric-side mux: address by grant, write data by data owner.
  always_comb begin
    HADDR  = own_m1 ? m1_HADDR  : m0_HADDR;
    HWRITE = own_m1 ? m1_HWRITE : m0_HWRITE;
    HSIZE  = own_m1 ? m1_HSIZE  : m0_HSIZE;
    HTRANS = preempt ? TransIdle : owner_htrans;
    HWDATA = data_owner_q ? m1_HWDATA : m0_HWDATA;
  end

  // Per-master ready; a preempted owner is stalled until regranted.
  always_comb begin
    m0_HREADY = HREADY & (grant_q[0] | ~data_owner_q) & ~(grant_q[0] & preempt);
    m1_HREADY = HREADY & (grant_q[1] |  data_owner_q) & ~(grant_q[1] & preempt);
  end

  assign grant = grant_q;

endmodule
